serial_tx: RTL and testbench

//   Single-wire serial transmitter: drives the 1-bit line sampled by the d_ff/serial capture path.

---
 rtl/serial_tx.sv | 116 +++++++++++
 tb/tb_serial_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - framed LSB-first serial transmitter (START, DATA, STOP), CLKS_PER_BIT clocks per bit
`timescale 1ns/100ps
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_line,
    output logic              tx_busy
);

    localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                line_q, line_d;
    logic                busy_q, busy_d;
    logic                tick_end;
    logic [DATA_W-1:0]   shifted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tick_q  <= '0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tick_q  <= tick_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
        end
    end

    // With CLKS_PER_BIT=1 TICK_LAST is 0, so every cycle ends a bit and tick never leaves 0.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        tick_d   = tick_q;
        line_d   = line_q;
        busy_d   = busy_q;
        tick_end = (tick_q == TICK_LAST);
        shifted  = shift_q >> 1;
        case (state_q)
            IDLE: begin
                line_d = 1'b1;
                if (tx_valid) begin
                    state_d = START;
                    shift_d = tx_data;
                    line_d  = 1'b0;
                    busy_d  = 1'b1;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (tick_end) begin
                    state_d = DATA;
                    line_d  = shift_q[0];
                    bit_d   = '0;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            DATA: begin
                if (tick_end) begin
                    tick_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        line_d  = 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shifted;
                        line_d  = shifted[0];
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            STOP: begin
                if (tick_end) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (state_q == IDLE);
        tx_line  = line_q;
        tx_busy  = busy_q;
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - scoreboard bench for serial_tx (8-bit/4-clk and 4-bit/1-clk instances)
`timescale 1ns/100ps
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data_a = 8'h00;
    logic       tx_valid_a = 1'b0;
    logic       ready_a, line_a, busy_a;
    logic [3:0] tx_data_b = 4'h0;
    logic       tx_valid_b = 1'b0;
    logic       ready_b, line_b, busy_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q0[$];
    logic [3:0] exp_q1[$];

    bit         mon_active[2];
    int         mon_k[2];
    logic [7:0] mon_word[2];
    int         gap[2];
    int         last_gap[2];
    int         frames[2];

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(ready_a), .tx_line(line_a), .tx_busy(busy_a)
    );

    serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(ready_b), .tx_line(line_b), .tx_busy(busy_b)
    );

    always #1 clk = ~clk;

    task automatic chk(input bit ok, input string name, input int act, input int exp_v);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference: a frame is bit 0 = 0, bits 1..dw = payload LSB-first, bit dw+1 = 1, each held cpb cycles.
    task automatic mon_step(input int id, input int dw, input int cpb,
                            input logic rstv, input logic line, input logic busy, input logic ready);
        int   n;
        int   b;
        int   sz;
        logic e;
        if (!rstv) begin
            mon_active[id] = 1'b0;
            gap[id] = 0;
            chk(line === 1'b1 && busy === 1'b0 && ready === 1'b1, "reset_state", {line, busy, ready}, 5);
            return;
        end
        n = (dw + 2) * cpb;
        if (!mon_active[id] && busy === 1'b1) begin
            sz = (id == 0) ? exp_q0.size() : exp_q1.size();
            chk(sz > 0, "frame_expected", sz, 1);
            mon_word[id] = 8'h00;
            if (sz > 0) mon_word[id] = (id == 0) ? exp_q0.pop_front() : {4'h0, exp_q1.pop_front()};
            mon_active[id] = 1'b1;
            mon_k[id] = 0;
            last_gap[id] = gap[id];
            frames[id]++;
        end
        if (mon_active[id]) begin
            if (mon_k[id] < n) begin
                b = mon_k[id] / cpb;
                e = (b == 0) ? 1'b0 : (b <= dw) ? mon_word[id][b-1] : 1'b1;
                chk(line === e && busy === 1'b1 && ready === 1'b0,
                    (id == 0) ? "frame_bit_a" : "frame_bit_b", {line, busy, ready}, {e, 2'b10});
                mon_k[id]++;
            end else begin
                chk(line === 1'b1 && busy === 1'b0 && ready === 1'b1,
                    (id == 0) ? "frame_end_a" : "frame_end_b", {line, busy, ready}, 5);
                mon_active[id] = 1'b0;
                gap[id] = 1;
            end
        end else begin
            chk(line === 1'b1 && ready === 1'b1, (id == 0) ? "idle_a" : "idle_b", {line, ready}, 3);
            gap[id]++;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, 8, 4, rst, line_a, busy_a, ready_a);
        mon_step(1, 4, 1, rst, line_b, busy_b, ready_b);
    end

    task automatic send_a(input logic [7:0] w, input bit hold);
        int t;
        @(negedge clk);
        tx_data_a  = w;
        tx_valid_a = 1'b1;
        exp_q0.push_back(w);
        t = 0;
        while (!ready_a && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(t < 200, "accept_timeout_a", t, 200);
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            tx_valid_a = 1'b0;
            tx_data_a  = 8'($urandom);
        end
    endtask

    task automatic send_b(input logic [3:0] w, input bit hold);
        int t;
        @(negedge clk);
        tx_data_b  = w;
        tx_valid_b = 1'b1;
        exp_q1.push_back(w);
        t = 0;
        while (!ready_b && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(t < 200, "accept_timeout_b", t, 200);
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            tx_valid_b = 1'b0;
            tx_data_b  = 4'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got %0d expected %0d", 1, 0);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        bit hold;
        int t;
        #0.2 rst = 1'b0;
        #0.3;
        chk(line_a === 1'b1 && ready_a === 1'b1 && busy_a === 1'b0, "reset_outputs", {line_a, ready_a, busy_a}, 6);
        #5;
        chk(line_a === 1'b1 && ready_a === 1'b1 && busy_a === 1'b0, "reset_outputs_late", {line_a, ready_a, busy_a}, 6);
        #4.5 rst = 1'b1;
        repeat (20) @(negedge clk);
        chk(frames[0] == 0 && line_a === 1'b1, "idle_after_reset", frames[0], 0);

        send_a(8'hA5, 1'b0);
        chk(busy_a === 1'b1 && ready_a === 1'b0, "accept_same_edge", {busy_a, ready_a}, 2);
        repeat (45) @(negedge clk);

        send_a(8'h00, 1'b1);
        send_a(8'hFF, 1'b0);
        @(negedge clk);
        #0.1;
        chk(last_gap[0] == 1, "back_to_back_gap", last_gap[0], 1);
        repeat (45) @(negedge clk);

        send_a(8'h81, 1'b0);
        repeat (15) @(negedge clk);
        send_a(8'h3C, 1'b0);
        repeat (45) @(negedge clk);

        send_a(8'hC3, 1'b0);
        repeat (17) @(negedge clk);
        #0.3 rst = 1'b0;
        #0.1;
        chk(line_a === 1'b1 && busy_a === 1'b0, "async_reset_mid_frame", {line_a, busy_a}, 2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send_a(8'h5A, 1'b0);
        repeat (45) @(negedge clk);

        send_b(4'h9, 1'b0);
        repeat (10) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            hold = (i < 19) && ($urandom_range(0, 3) == 0);
            send_a(8'($urandom), hold);
            if (!hold) repeat ($urandom_range(0, 50)) @(negedge clk);
        end
        for (int i = 0; i < 30; i++) begin
            hold = (i < 29) && ($urandom_range(0, 2) == 0);
            send_b(4'($urandom), hold);
            if (!hold) repeat ($urandom_range(0, 8)) @(negedge clk);
        end

        t = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || mon_active[0] || mon_active[1]) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk(exp_q0.size() == 0, "drain_a", exp_q0.size(), 0);
        chk(exp_q1.size() == 0, "drain_b", exp_q1.size(), 0);
        chk(frames[1] == 31, "frames_b", frames[1], 31);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
